mac_tile_gen: RTL and testbench

- Parametrised next-generation processing element for the systolic MAC array. Drop-in successor to the current tile.
- Generalises activation slicing to any number of slices: NS = bw/slice_bw.
- Each slice has its own stored weight, loaded over NS cycles.
- Adds an output-stationary (OS) mode with an internal accumulator and a flush/drain instruction, alongside the existing weight-stationary (WS) psum pass-through.

---
 rtl/mac_tile_gen.sv | 152 +++++++++++++++
 tb/tb_mac_tile_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tile_gen.sv
`default_nettype none
// ============================================================================
// Module   : mac_tile_gen
// Purpose  : Systolic MAC processing element. Supports full-precision or
//            sliced activations (bw/slice_bw slices, one stored weight per
//            slice). Operates in weight-stationary psum pass-through mode or
//            output-stationary mode, which adds an accumulator and a
//            flush/drain instruction.
//            bw must be an integer multiple of slice_bw with bw/slice_bw >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module mac_tile_gen #(
  parameter int bw       = 4,
  parameter int psum_bw  = 16,
  parameter int slice_bw = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [bw-1:0]      in_w,
  output logic [bw-1:0]      out_e,
  input  logic [2:0]         inst_w,
  output logic [2:0]         inst_e,
  input  logic [psum_bw-1:0] in_n,
  output logic [psum_bw-1:0] out_s,
  input  logic               mode,
  input  logic               os_mode
);

  localparam int c_ns    = bw / slice_bw;
  localparam int c_cnt_w = (c_ns > 1) ? $clog2(c_ns) : 1;
  localparam logic [c_cnt_w-1:0] c_last_slot = c_cnt_w'(c_ns - 1);

  // Registered state
  logic [bw-1:0]      r_a;
  logic [bw-1:0]      r_b [c_ns];
  logic [psum_bw-1:0] r_c;
  logic [psum_bw-1:0] r_acc;
  logic [psum_bw-1:0] r_d;
  logic [c_cnt_w-1:0] r_load_cnt;
  logic               r_inst_ld;
  logic [1:0]         r_inst_hi;

  // Combinational nets
  logic [c_ns*bw-1:0] w_b_flat;
  logic [psum_bw-1:0] w_prod_reg;
  logic [psum_bw-1:0] w_prod_in;
  logic [psum_bw-1:0] w_acc_next;
  logic               w_flush;
  logic               w_load_last;

  // Weights are signed, activations (and slices) unsigned. Working at
  // psum_bw directly gives the sign-extended, wrapping product for free.
  function automatic logic [psum_bw-1:0] f_prod(
    input logic [bw-1:0]      act,
    input logic               sliced,
    input logic [c_ns*bw-1:0] wts
  );
    logic [psum_bw-1:0] sum;
    logic [psum_bw-1:0] a_ext;
    logic [psum_bw-1:0] b_ext;
    sum = '0;
    if (!sliced) begin
      a_ext = psum_bw'(act);
      b_ext = psum_bw'($signed(wts[bw-1:0]));
      sum   = a_ext * b_ext;
    end else begin
      for (int k = 0; k < c_ns; k++) begin
        a_ext = psum_bw'(act[k*slice_bw +: slice_bw]);
        b_ext = psum_bw'($signed(wts[k*bw +: bw]));
        sum   = sum + a_ext * b_ext;
      end
    end
    return sum;
  endfunction

  // Flatten the weight bank so it can be handed to the product function
  generate
    for (genvar k = 0; k < c_ns; k++) begin : g_flat
      assign w_b_flat[k*bw +: bw] = r_b[k];
    end
  endgenerate

  // Product of the latched activation (WS output) and of the incoming
  // activation (OS accumulate, which uses the weights before any same-cycle load)
  assign w_prod_reg  = f_prod(r_a, mode, w_b_flat);
  assign w_prod_in   = f_prod(in_w, mode, w_b_flat);
  assign w_acc_next  = (os_mode && inst_w[1]) ? (r_acc + w_prod_in) : r_acc;
  assign w_flush     = os_mode & inst_w[2];
  assign w_load_last = (r_load_cnt == c_last_slot);

  assign out_e  = r_a;
  assign inst_e = {r_inst_hi, r_inst_ld};
  assign out_s  = os_mode ? r_d : (r_c + w_prod_reg);

  // Activation latch, psum capture and execute/flush forwarding
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a       <= '0;
      r_c       <= '0;
      r_inst_hi <= 2'b00;
    end else begin
      if (inst_w[0] || inst_w[1]) begin
        r_a <= in_w;
      end
      r_c       <= in_n;
      r_inst_hi <= inst_w[2:1];
    end
  end

  // Weight load: broadcast in full mode, one slot per cycle in sliced mode.
  // Leaving sliced loading (idle or switching to full mode) restarts at slot 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < c_ns; k++) begin
        r_b[k] <= '0;
      end
      r_load_cnt <= '0;
      r_inst_ld  <= 1'b0;
    end else if (inst_w[0]) begin
      if (!mode) begin
        for (int k = 0; k < c_ns; k++) begin
          r_b[k] <= in_w;
        end
        r_load_cnt <= '0;
        r_inst_ld  <= 1'b1;
      end else begin
        r_b[r_load_cnt] <= in_w;
        r_inst_ld       <= w_load_last;
        r_load_cnt      <= w_load_last ? '0 : (r_load_cnt + 1'b1);
      end
    end else begin
      r_load_cnt <= '0;
      r_inst_ld  <= 1'b0;
    end
  end

  // Output-stationary accumulator and drain register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_d   <= '0;
    end else if (w_flush) begin
      r_d   <= w_acc_next;
      r_acc <= '0;
    end else begin
      r_d   <= in_n;
      r_acc <= w_acc_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_tile_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_tile_gen
// Purpose  : Self-checking bench for mac_tile_gen: directed vector table,
//            reset-during-load sequence and randomized run against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_tile_gen;

  localparam int BW   = 4;
  localparam int PB   = 16;
  localparam int SB   = 2;
  localparam int NS   = BW / SB;
  localparam int MASK = (1 << PB) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] in_w;
  logic [BW-1:0] out_e;
  logic [2:0]    inst_w;
  logic [2:0]    inst_e;
  logic [PB-1:0] in_n;
  logic [PB-1:0] out_s;
  logic          mode;
  logic          os_mode;

  mac_tile_gen #(.bw(BW), .psum_bw(PB), .slice_bw(SB)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_w    (in_w),
    .out_e   (out_e),
    .inst_w  (inst_w),
    .inst_e  (inst_e),
    .in_n    (in_n),
    .out_s   (out_s),
    .mode    (mode),
    .os_mode (os_mode)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle just after the edge
  task automatic apply(input logic [3:0] w, input logic [2:0] inst, input logic [15:0] n,
                       input logic md, input logic os);
    in_w    = w;
    inst_w  = inst;
    in_n    = n;
    mode    = md;
    os_mode = os;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  w;
    logic [2:0]  inst;
    logic [15:0] n;
    logic        md;
    logic        os;
    logic [3:0]  e_out_e;
    logic [2:0]  e_inst_e;
    logic [15:0] e_out_s;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic [3:0] w, input logic [2:0] inst, input logic [15:0] n,
                              input logic md, input logic os, input logic [3:0] ee,
                              input logic [2:0] ie, input logic [15:0] es);
    vec_t v;
    v.w = w; v.inst = inst; v.n = n; v.md = md; v.os = os;
    v.e_out_e = ee; v.e_inst_e = ie; v.e_out_s = es;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int         m_a, m_cnt, m_c, m_acc, m_d;
  int         m_w[NS];
  logic [2:0] m_inst;

  function automatic int sx(input int v);
    return (v >= (1 << (BW - 1))) ? v - (1 << BW) : v;
  endfunction

  function automatic int calc(input int act, input bit md);
    int s;
    s = 0;
    if (!md) s = act * m_w[0];
    else
      for (int k = 0; k < NS; k++)
        s += ((act >> (k * SB)) & ((1 << SB) - 1)) * m_w[k];
    return s & MASK;
  endfunction

  task automatic m_reset();
    m_a = 0; m_cnt = 0; m_c = 0; m_acc = 0; m_d = 0; m_inst = 3'b000;
    for (int k = 0; k < NS; k++) m_w[k] = 0;
  endtask

  task automatic m_step(input int w, input logic [2:0] inst, input int n, input bit md, input bit os);
    int p_in;
    int nxt;
    p_in = calc(w, md);
    if (os) begin
      nxt = m_acc + (inst[1] ? p_in : 0);
      if (inst[2]) begin
        m_d   = nxt & MASK;
        m_acc = 0;
      end else begin
        m_d   = n;
        m_acc = nxt & MASK;
      end
    end else begin
      m_d = n;
    end
    if (inst[0]) begin
      if (!md) begin
        for (int k = 0; k < NS; k++) m_w[k] = sx(w);
        m_inst[0] = 1'b1;
        m_cnt     = 0;
      end else begin
        m_w[m_cnt] = sx(w);
        m_inst[0]  = (m_cnt == NS - 1);
        m_cnt      = (m_cnt + 1) % NS;
      end
    end else begin
      m_inst[0] = 1'b0;
      m_cnt     = 0;
    end
    if (inst[0] || inst[1]) m_a = w;
    m_c       = n;
    m_inst[2] = inst[2];
    m_inst[1] = inst[1];
  endtask

  function automatic int m_out_s(input bit md, input bit os);
    return os ? m_d : ((m_c + calc(m_a, md)) & MASK);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  rw;
    logic [2:0]  ri;
    logic [15:0] rn;
    logic        rm;
    logic        ro;

    //      w      inst    in_n      md  os  out_e  inst_e  out_s
    tbl[0]  = mk(4'h3, 3'b001, 16'h0000, 1, 0, 4'h3, 3'b000, 16'h0009);
    tbl[1]  = mk(4'hE, 3'b001, 16'h0000, 1, 0, 4'hE, 3'b001, 16'h0000);
    tbl[2]  = mk(4'hE, 3'b010, 16'd10,   1, 0, 4'hE, 3'b010, 16'd10);
    tbl[3]  = mk(4'hD, 3'b001, 16'h0000, 0, 0, 4'hD, 3'b001, 16'hFFD9);
    tbl[4]  = mk(4'hF, 3'b010, 16'h0000, 0, 0, 4'hF, 3'b010, 16'hFFD3);
    tbl[5]  = mk(4'h1, 3'b001, 16'h0000, 0, 0, 4'h1, 3'b001, 16'h0001);
    tbl[6]  = mk(4'h1, 3'b010, 16'h7FFF, 0, 0, 4'h1, 3'b010, 16'h8000);
    tbl[7]  = mk(4'h2, 3'b001, 16'h0000, 0, 1, 4'h2, 3'b001, 16'h0000);
    tbl[8]  = mk(4'h1, 3'b010, 16'h0055, 0, 1, 4'h1, 3'b010, 16'h0055);
    tbl[9]  = mk(4'h2, 3'b010, 16'h0066, 0, 1, 4'h2, 3'b010, 16'h0066);
    tbl[10] = mk(4'h3, 3'b010, 16'h0000, 0, 1, 4'h3, 3'b010, 16'h0000);
    tbl[11] = mk(4'h0, 3'b100, 16'h0077, 0, 1, 4'h3, 3'b100, 16'h000C);
    tbl[12] = mk(4'h0, 3'b000, 16'h0011, 0, 1, 4'h3, 3'b000, 16'h0011);
    tbl[13] = mk(4'h5, 3'b010, 16'h0000, 0, 1, 4'h5, 3'b010, 16'h0000);
    tbl[14] = mk(4'h0, 3'b100, 16'h0000, 0, 1, 4'h5, 3'b100, 16'h000A);
    tbl[15] = mk(4'h1, 3'b001, 16'h0000, 0, 1, 4'h1, 3'b001, 16'h0000);
    tbl[16] = mk(4'h7, 3'b010, 16'h0000, 0, 1, 4'h7, 3'b010, 16'h0000);
    tbl[17] = mk(4'h2, 3'b001, 16'h0000, 0, 1, 4'h2, 3'b001, 16'h0000);
    tbl[18] = mk(4'h1, 3'b110, 16'h0000, 0, 1, 4'h1, 3'b110, 16'h0009);
    tbl[19] = mk(4'h0, 3'b100, 16'h1234, 0, 1, 4'h1, 3'b100, 16'h0000);
    tbl[20] = mk(4'h0, 3'b000, 16'h1234, 0, 1, 4'h1, 3'b000, 16'h1234);
    tbl[21] = mk(4'h0, 3'b100, 16'h0005, 0, 0, 4'h1, 3'b100, 16'h0007);
    tbl[22] = mk(4'h3, 3'b011, 16'h0000, 0, 1, 4'h3, 3'b011, 16'h0000);
    tbl[23] = mk(4'h0, 3'b100, 16'h0000, 0, 1, 4'h3, 3'b100, 16'h0006);

    // Reset state
    reset = 1'b0; in_w = '0; inst_w = '0; in_n = '0; mode = 1'b0; os_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_e", 32'(out_e), 32'h0);
    check("reset_inst_e", 32'(inst_e), 32'h0);
    check("reset_out_s", 32'(out_s), 32'h0);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].w, tbl[i].inst, tbl[i].n, tbl[i].md, tbl[i].os);
      check($sformatf("vec%0d_out_e", i), 32'(out_e), 32'(tbl[i].e_out_e));
      check($sformatf("vec%0d_inst_e", i), 32'(inst_e), 32'(tbl[i].e_inst_e));
      check($sformatf("vec%0d_out_s", i), 32'(out_s), 32'(tbl[i].e_out_s));
    end

    // Reset in the middle of a sliced load, then a fresh load from slot 0
    apply(4'h3, 3'b001, 16'h0000, 1, 0);
    check("midload_first_inst_e", 32'(inst_e), 32'h0);
    reset = 1'b0;
    #1;
    check("midload_rst_out_e", 32'(out_e), 32'h0);
    check("midload_rst_inst_e", 32'(inst_e), 32'h0);
    check("midload_rst_out_s", 32'(out_s), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply(4'h1, 3'b001, 16'h0000, 1, 0);
    check("reload_slot0_inst_e", 32'(inst_e), 32'h0);
    apply(4'h2, 3'b001, 16'h0000, 1, 0);
    check("reload_slot1_inst_e", 32'(inst_e), 32'h1);
    apply(4'b0101, 3'b010, 16'h0000, 1, 0);
    check("reload_exec_out_s", 32'(out_s), 32'h3);

    // Randomized run against the reference model
    reset = 1'b0;
    inst_w = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_reset();
    rm = 1'b0;
    ro = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rw = 4'($urandom_range(0, 15));
      ri = 3'($urandom_range(0, 7));
      rn = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rm = ~rm;
      if ($urandom_range(0, 15) == 0) ro = ~ro;
      m_step(int'(rw), ri, int'(rn), rm, ro);
      apply(rw, ri, rn, rm, ro);
      check($sformatf("rand%0d_out_e", i), 32'(out_e), 32'(m_a));
      check($sformatf("rand%0d_inst_e", i), 32'(inst_e), 32'(m_inst));
      check($sformatf("rand%0d_out_s", i), 32'(out_s), 32'(m_out_s(rm, ro)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
